// File: rtl/cpu_pkg.sv
// Shared datapath widths, ALU opcodes and the EX-register layout for the
// decode/execute slice of the 16-bit core.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int CTRL_W = 3;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_AND  = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_OR   = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_SLTI = 3'b100;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [CTRL_W-1:0] alu_control;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } ex_reg_t;

  // True when a writer of rd collides with a source of the decoded instruction;
  // r0 never carries a dependency and rt is ignored for immediate forms.
  function automatic logic rd_hits(input logic [REG_AW-1:0] rd,
                                   input logic              we,
                                   input logic [REG_AW-1:0] rs,
                                   input logic [REG_AW-1:0] rt,
                                   input logic              use_imm);
    return we && (rd != '0) && ((rd == rs) || (!use_imm && (rd == rt)));
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass selector: youngest producer (EX/MEM) wins over MEM/WB,
// otherwise the value read from the register file at decode is kept.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exm_reg_write,
  input  logic              exm_mem_read,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] operand
);

  // A load in EX/MEM has no data yet, so it is never a bypass source.
  always_comb begin
    operand = reg_data;
    if (exm_reg_write && !exm_mem_read && (exm_rd != '0) && (exm_rd == src))
      operand = exm_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src))
      operand = wb_data;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register feeding the ALU, with hazard stalls, flushes and operand
// bypassing. Define FORWARDING_EN for bypass muxes; otherwise RAW hazards stall.
module ex_operand_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [CTRL_W-1:0] id_alu_control,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              mem_stall,
  input  logic              ex_flush,
  input  logic              exm_reg_write,
  input  logic              exm_mem_read,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [CTRL_W-1:0] alu_control,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [15:0]       hazard_stalls
);

  ex_reg_t           ex_q;
  ex_reg_t           id_entry;
  logic              flush_pend;
  logic              flush_eff;
  logic              hazard;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  assign id_entry = '{valid: 1'b1, rs: id_rs, rt: id_rt, rs_data: id_rs_data,
                      rt_data: id_rt_data, imm: id_imm, use_imm: id_use_imm,
                      alu_control: id_alu_control, rd: id_rd,
                      reg_write: id_reg_write, mem_read: id_mem_read};

  assign flush_eff = ex_flush | flush_pend;

`ifdef FORWARDING_EN
  assign hazard = rd_hits(ex_q.rd, ex_q.valid && ex_q.mem_read, id_rs, id_rt, id_use_imm);

  fwd_mux u_fwd_a (
    .src(ex_q.rs), .reg_data(ex_q.rs_data),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .operand(fwd_a)
  );

  fwd_mux u_fwd_b (
    .src(ex_q.rt), .reg_data(ex_q.rt_data),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .operand(fwd_b)
  );
`else
  // Without bypassing, wait until the producer has retired into the register file.
  assign hazard = rd_hits(ex_q.rd, ex_q.valid && ex_q.reg_write, id_rs, id_rt, id_use_imm)
                | rd_hits(exm_rd, exm_reg_write, id_rs, id_rt, id_use_imm)
                | rd_hits(wb_rd, wb_reg_write, id_rs, id_rt, id_use_imm);

  assign fwd_a = ex_q.rs_data;
  assign fwd_b = ex_q.rt_data;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{exm_mem_read, exm_result, wb_data, ex_q.rs, ex_q.rt};
`endif

  // A flush overrides the hazard: the decode slot is being discarded anyway.
  assign id_ready = !mem_stall && (flush_eff || !hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q          <= '0;
      flush_pend    <= 1'b0;
      hazard_stalls <= '0;
    end else begin
      if (!mem_stall) begin
        flush_pend <= 1'b0;
        if (id_valid && id_ready && !flush_eff)
          ex_q <= id_entry;
        else
          ex_q <= '0;
      end else if (ex_flush) begin
        flush_pend <= 1'b1;
      end
      if (id_valid && !id_ready && !mem_stall && (hazard_stalls != 16'hFFFF))
        hazard_stalls <= hazard_stalls + 16'd1;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign alu_control  = ex_q.alu_control;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign op_a         = ex_q.valid ? fwd_a : '0;
  assign op_b         = !ex_q.valid ? '0 : (ex_q.use_imm ? ex_q.imm : fwd_b);

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; expectations follow FORWARDING_EN the
// same way the design does.
module tb_ex_operand_stage;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid, id_ready;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic              id_use_imm, id_reg_write, id_mem_read;
  logic [CTRL_W-1:0] id_alu_control;
  logic              mem_stall, ex_flush;
  logic              exm_reg_write, exm_mem_read;
  logic [REG_AW-1:0] exm_rd, wb_rd;
  logic [DATA_W-1:0] exm_result, wb_data;
  logic              wb_reg_write;
  logic              ex_valid;
  logic [DATA_W-1:0] op_a, op_b;
  logic [CTRL_W-1:0] alu_control;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write, ex_mem_read;
  logic [15:0]       hazard_stalls;

  int compared   = 0;
  int mismatched = 0;
  int exp_stalls = 0;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_control(id_alu_control),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_stall(mem_stall), .ex_flush(ex_flush),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .op_a(op_a), .op_b(op_b), .alu_control(alu_control),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .hazard_stalls(hazard_stalls)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [REG_AW-1:0] rs,
                               input logic [REG_AW-1:0] rt, input logic [DATA_W-1:0] rs_d,
                               input logic [DATA_W-1:0] rt_d, input logic [DATA_W-1:0] imm,
                               input logic use_imm, input logic [CTRL_W-1:0] ctrl,
                               input logic [REG_AW-1:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_data = rs_d; id_rt_data = rt_d;
    id_imm = imm; id_use_imm = use_imm; id_alu_control = ctrl; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0, ALU_ADD, 0, 1'b0, 1'b0);
    mem_stall = 1'b0; ex_flush = 1'b0;
    exm_reg_write = 1'b0; exm_mem_read = 1'b0; exm_rd = '0; exm_result = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0, ALU_ADD, 0, 1'b0, 1'b0);
    mem_stall = 1'b0; ex_flush = 1'b0;
    exm_reg_write = 1'b0; exm_mem_read = 1'b0; exm_rd = '0; exm_result = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    #2;
    checkOutput("rst_ex_valid", ex_valid, 0);
    checkOutput("rst_op_a", op_a, 0);
    checkOutput("rst_op_b", op_b, 0);
    checkOutput("rst_stalls", hazard_stalls, 0);
    checkOutput("rst_id_ready", id_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // add r1 = r2 + r3, then dependent sub r4 = r1 - r3 with stale rs data
    applyStimulus(1'b1, 2, 3, 16'd5, 16'd7, 0, 1'b0, ALU_ADD, 1, 1'b1, 1'b0);
    checkOutput("s1_add_ready", id_ready, 1);
    tick();
    checkOutput("s1_add_valid", ex_valid, 1);
    checkOutput("s1_add_op_a", op_a, 16'd5);
    checkOutput("s1_add_op_b", op_b, 16'd7);
    checkOutput("s1_add_rd", ex_rd, 1);
    checkOutput("s1_add_rw", ex_reg_write, 1);
    applyStimulus(1'b1, 1, 3, 16'd0, 16'd7, 0, 1'b0, ALU_SUB, 4, 1'b1, 1'b0);
`ifdef FORWARDING_EN
    checkOutput("s1_sub_ready", id_ready, 1);
    tick();
    exm_reg_write = 1'b1; exm_rd = 1; exm_result = 16'd12; #1;
`else
    checkOutput("s1_stall0_ready", id_ready, 0);
    tick(); exp_stalls++;
    exm_reg_write = 1'b1; exm_rd = 1; exm_result = 16'd12; #1;
    checkOutput("s1_stall1_ready", id_ready, 0);
    checkOutput("s1_bubble_valid", ex_valid, 0);
    tick(); exp_stalls++;
    exm_reg_write = 1'b0; wb_reg_write = 1'b1; wb_rd = 1; wb_data = 16'd12; #1;
    checkOutput("s1_stall2_ready", id_ready, 0);
    tick(); exp_stalls++;
    wb_reg_write = 1'b0; id_rs_data = 16'd12; #1;
    checkOutput("s1_release_ready", id_ready, 1);
    tick();
`endif
    checkOutput("s1_sub_op_a", op_a, 16'd12);
    checkOutput("s1_sub_op_b", op_b, 16'd7);
    checkOutput("s1_sub_ctrl", alu_control, ALU_SUB);
    checkOutput("s1_stalls", hazard_stalls, exp_stalls[15:0]);
    idle();

    // lw r1, 4(r2) followed by add r2 = r1 + r1
    applyStimulus(1'b1, 2, 0, 16'h0010, 0, 16'd4, 1'b1, ALU_ADD, 1, 1'b1, 1'b1);
    checkOutput("s2_lw_ready", id_ready, 1);
    tick();
    checkOutput("s2_lw_op_a", op_a, 16'h0010);
    checkOutput("s2_lw_op_b", op_b, 16'h0004);
    checkOutput("s2_lw_mem_read", ex_mem_read, 1);
    applyStimulus(1'b1, 1, 1, 0, 0, 0, 1'b0, ALU_ADD, 2, 1'b1, 1'b0);
    checkOutput("s2_use_ready", id_ready, 0);
    tick(); exp_stalls++;
    exm_reg_write = 1'b1; exm_mem_read = 1'b1; exm_rd = 1; exm_result = 16'h0014; #1;
    checkOutput("s2_bubble_valid", ex_valid, 0);
`ifdef FORWARDING_EN
    checkOutput("s2_retry_ready", id_ready, 1);
    tick();
    exm_reg_write = 1'b0; exm_mem_read = 1'b0;
    wb_reg_write = 1'b1; wb_rd = 1; wb_data = 16'h00A5; #1;
`else
    checkOutput("s2_stall1_ready", id_ready, 0);
    tick(); exp_stalls++;
    exm_reg_write = 1'b0; exm_mem_read = 1'b0;
    wb_reg_write = 1'b1; wb_rd = 1; wb_data = 16'h00A5; #1;
    checkOutput("s2_stall2_ready", id_ready, 0);
    tick(); exp_stalls++;
    wb_reg_write = 1'b0; id_rs_data = 16'h00A5; id_rt_data = 16'h00A5; #1;
    checkOutput("s2_release_ready", id_ready, 1);
    tick();
`endif
    checkOutput("s2_add_op_a", op_a, 16'h00A5);
    checkOutput("s2_add_op_b", op_b, 16'h00A5);
    checkOutput("s2_stalls", hazard_stalls, exp_stalls[15:0]);
    idle();

    // writes to r0 downstream must not be bypassed into an r0 consumer
    exm_reg_write = 1'b1; exm_rd = 0; exm_result = 16'hFFFF;
    wb_reg_write = 1'b1; wb_rd = 0; wb_data = 16'hFFFF;
    applyStimulus(1'b1, 0, 2, 0, 16'd9, 0, 1'b0, ALU_ADD, 3, 1'b1, 1'b0);
    checkOutput("s3_ready", id_ready, 1);
    tick();
    checkOutput("s3_op_a", op_a, 16'd0);
    checkOutput("s3_op_b", op_b, 16'd9);
    idle();

    // three-cycle mem stall with a flush in the second stall cycle
    applyStimulus(1'b1, 6, 7, 16'h00F0, 16'h000F, 0, 1'b0, ALU_OR, 5, 1'b1, 1'b0);
    tick();
    checkOutput("s4_or_op_a", op_a, 16'h00F0);
    checkOutput("s4_or_ctrl", alu_control, ALU_OR);
    mem_stall = 1'b1;
    applyStimulus(1'b1, 2, 3, 16'h1111, 16'h2222, 0, 1'b0, ALU_AND, 1, 1'b1, 1'b0);
    checkOutput("s4_stall_ready", id_ready, 0);
    tick();
    checkOutput("s4_frz1_op_a", op_a, 16'h00F0);
    checkOutput("s4_frz1_valid", ex_valid, 1);
    ex_flush = 1'b1; #1;
    checkOutput("s4_flush_ready", id_ready, 0);
    tick();
    checkOutput("s4_frz2_op_b", op_b, 16'h000F);
    ex_flush = 1'b0; #1;
    tick();
    checkOutput("s4_frz3_op_a", op_a, 16'h00F0);
    checkOutput("s4_frz3_ctrl", alu_control, ALU_OR);
    mem_stall = 1'b0; #1;
    checkOutput("s4_pend_ready", id_ready, 1);
    tick();
    checkOutput("s4_flushed_valid", ex_valid, 0);
    checkOutput("s4_flushed_op_a", op_a, 16'd0);
    checkOutput("s4_next_ready", id_ready, 1);
    tick();
    checkOutput("s4_next_valid", ex_valid, 1);
    checkOutput("s4_next_op_a", op_a, 16'h1111);
    checkOutput("s4_next_ctrl", alu_control, ALU_AND);
    checkOutput("s4_stalls", hazard_stalls, exp_stalls[15:0]);
    idle();

    // asynchronous reset while a load-use stall is pending
    applyStimulus(1'b1, 2, 0, 16'h0010, 0, 16'd4, 1'b1, ALU_ADD, 1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1, 1, 0, 0, 0, 1'b0, ALU_ADD, 2, 1'b1, 1'b0);
    checkOutput("s5_pre_ready", id_ready, 0);
    checkOutput("s5_pre_stalls", hazard_stalls, exp_stalls[15:0]);
    rst_n = 1'b0; #1;
    checkOutput("s5_rst_valid", ex_valid, 0);
    checkOutput("s5_rst_op_a", op_a, 0);
    checkOutput("s5_rst_op_b", op_b, 0);
    checkOutput("s5_rst_mem_read", ex_mem_read, 0);
    checkOutput("s5_rst_stalls", hazard_stalls, 0);
    checkOutput("s5_rst_ready", id_ready, 1);
    idle();
    rst_n = 1'b1;
    tick();
    checkOutput("s5_post_valid", ex_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the 16-bit ALU. It captures a decoded instruction from the decode stage and holds it in the EX register. Its outputs drive the ALU operands `op_a`, `op_b` and `alu_control`. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and inserts a one-cycle bubble on a load-use hazard. It also honours memory-stage stalls and branch flushes.

## Interface
- `DATA_W`, 16, datapath width.
- `REG_AW`, 3, register index width (8 registers, r0 hardwired zero).
- `CTRL_W`, 3, ALU control width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  decoded instruction present.
- `id_ready`  out  1  stage accepts the ID instruction this cycle.
- `id_rs`, `id_rt`  in  REG_AW  source register indices.
- `id_rs_data`, `id_rt_data`  in  DATA_W  register-file read values.
- `id_imm`  in  DATA_W  sign-extended immediate.
- `id_use_imm`  in  1  `op_b` comes from the immediate; `rt` is not a source.
- `id_alu_control`  in  CTRL_W  ALU operation.
- `id_rd`  in  REG_AW  destination register.
- `id_reg_write`  in  1  instruction writes `id_rd`.
- `id_mem_read`  in  1  instruction is a load.
- `mem_stall`  in  1  downstream stall; freeze the EX register.
- `ex_flush`  in  1  squash the instruction being captured.
- `exm_reg_write`, `exm_mem_read`  in  1  EX/MEM control.
- `exm_rd`  in  REG_AW  EX/MEM destination register.
- `exm_result`  in  DATA_W  EX/MEM registered ALU result.
- `wb_reg_write`  in  1  MEM/WB write enable.
- `wb_rd`  in  REG_AW  MEM/WB destination register.
- `wb_data`  in  DATA_W  MEM/WB writeback value.
- `ex_valid`  out  1  EX register holds a real instruction.
- `op_a`, `op_b`  out  DATA_W  ALU operands.
- `alu_control`  out  CTRL_W  ALU operation.
- `ex_rd`  out  REG_AW  destination passed downstream.
- `ex_reg_write`, `ex_mem_read`  out  1  control passed downstream; both 0 when `ex_valid`=0.
- `hazard_stalls`  out  16  saturating count of hazard-stall cycles.

## Operation
- **EX register contents:**
  - Fields: `valid`, `rs`, `rt`, `rs_data`, `rt_data`, `imm`, `use_imm`, `alu_control`, `rd`, `reg_write`, `mem_read`.
  - Capture: `id_valid && id_ready && !flush_eff` loads the ID fields.
  - Otherwise, if `mem_stall` is low, the register loads a bubble (all fields 0).
- **Load-use hazard:**
  - Condition: EX register `valid && mem_read && rd!=0`, and `rd` equals `id_rs`, or equals `id_rt` when `!id_use_imm`.
  - Response: `id_ready`=0 for that cycle and a bubble is loaded.
- **Stall priority:** `mem_stall`=1 freezes the EX register and forces `id_ready`=0. It takes priority over the hazard and the flush.
- **Flush:**
  - `ex_flush` while `mem_stall`=0 gives `id_ready`=1, the ID instruction is discarded and a bubble is loaded.
  - `ex_flush` while `mem_stall`=1 sets a `flush_pend` bit.
  - `flush_eff = ex_flush | flush_pend`; `flush_pend` clears on the first non-stalled cycle.
- **Forwarding (per operand, combinational from the EX register):**
  - Priority 1: EX/MEM when `exm_reg_write && !exm_mem_read && exm_rd!=0 && exm_rd==src`.
  - Priority 2: MEM/WB when `wb_reg_write && wb_rd!=0 && wb_rd==src`.
  - Otherwise the registered value is used.
  - `op_b` takes `imm` when `use_imm`=1 and is then never forwarded.
  - When `ex_valid`=0, `op_a` and `op_b` are 0.
- **Stall counter:** `hazard_stalls` increments on each cycle with `id_valid && !id_ready && !mem_stall`, and saturates at 0xFFFF.
- **Reset:** every output and all state go to 0, including `flush_pend` and the counter, and `id_ready`=1. A mid-operation reset discards the in-flight instruction.

## Timing
- ID→EX latency is 1 cycle; the ALU sees the operands in the cycle after the handshake.
- `id_ready`, `op_a` and `op_b` are combinational; the forwarding path is EX/MEM/WB inputs → mux → ALU, in the same cycle.
- Load-use costs exactly one bubble, and the dependent instruction then forwards from MEM/WB.
- `ex_flush` and `mem_stall` are sampled at the rising edge.

## Configuration
- `FORWARDING_EN` defined:
  - Behaviour as described under Operation.
- `FORWARDING_EN` undefined:
  - The forwarding muxes are removed; `op_a`/`op_b` come straight from the EX register.
  - `id_ready`=0 while any ID source (excluding r0) matches a writing `rd` in the EX register, EX/MEM or MEM/WB.
  - A dependent immediately following its producer therefore stalls 3 cycles.

## Structure
- Shared package `cpu_pkg`:
  - `DATA_W`, `REG_AW`, `CTRL_W`.
  - ALU op constants: ADD=000, SUB=001, AND=010, OR=011, SLTI=100.
  - The EX-register struct typedef.
- One sub-module: `fwd_mux`, instantiated once per operand.

## Test plan
- **EX/MEM forwarding:** `add r1=r2+r3` (5, 7), then `sub r4=r1-r3` with a stale `id_rs_data`=0 → `op_a`=12 from `exm_result`, `op_b`=7, `id_ready` stays 1.
- **Load-use:** `lw r1` followed by `add r2=r1+r1` → `id_ready`=0 for one cycle and `ex_valid`=0 for one cycle; next cycle `op_a`=`op_b`=`wb_data`=0x00A5; `hazard_stalls`=1.
- **r0 writes:** EX/MEM and MEM/WB both write r0 with 0xFFFF and the consumer reads r0 → `op_a`=0 from the register file, with no forwarding.
- **Stall with flush:** `mem_stall` high for 3 cycles with `ex_flush` pulsed in stall cycle 2 → outputs frozen for 3 cycles; on release the EX register loads one bubble and the ID instruction is discarded.
- **Reset mid-load-use:** assert `rst_n` low during a load-use stall → `ex_valid`=0, operands 0, `hazard_stalls`=0, `id_ready`=1 immediately (asynchronous).
- **Without `FORWARDING_EN`:** repeat the EX/MEM forwarding scenario → `id_ready` low 3 cycles, then `op_a`=12 from `id_rs_data`.
